// File: rtl/cd_pkg.sv
// cd_pkg: definitions shared by the cardinal-mesh router blocks.
//   - Bit positions of the fields in a 64-bit packet (VC, X/Y direction
//     bits, X/Y hop counts).
//   - Output direction codes N/S/E/W/PE. A direction code is also the bit
//     index of that direction in a one-hot request vector.
//   - Width of the request vector, and a helper that turns a direction
//     code into a one-hot request.
package cd_pkg;

    localparam int VC     = 63;
    localparam int DIRX   = 62;  // 0 = east, 1 = west
    localparam int DIRY   = 61;  // 0 = north, 1 = south
    localparam int HX_MSB = 55;
    localparam int HX_LSB = 48;
    localparam int HY_MSB = 47;
    localparam int HY_LSB = 40;

    localparam int REQ_W = 5;

    typedef enum logic [2:0] {
        DIR_N  = 3'd0,
        DIR_S  = 3'd1,
        DIR_E  = 3'd2,
        DIR_W  = 3'd3,
        DIR_PE = 3'd4
    } dir_t;

    function automatic logic [REQ_W-1:0] dir_onehot(input dir_t d);
        return REQ_W'(1) << d;
    endfunction

endpackage

// File: rtl/route_xy.sv
// route_xy: purely combinational XY dimension-order routing helpers.
//   pkt        in  64  packet whose route is computed (the incoming link data)
//   route      out 5   one-hot output request {PE, W, E, S, N}
//   dir        out 3   the same route as a direction code
//   held       in  64  packet held in the buffer
//   held_route in  5   registered one-hot route of the held packet
//   held_dec   out 64  held packet with the routed dimension's hop count
//                      reduced by one. A PE route leaves the packet as is.
module route_xy
    import cd_pkg::*;
(
    input  logic [63:0]      pkt,
    output logic [REQ_W-1:0] route,
    output logic [2:0]       dir,
    input  logic [63:0]      held,
    input  logic [REQ_W-1:0] held_route,
    output logic [63:0]      held_dec
);

    dir_t d;

    // X is resolved first. Y is routed only once the X hops are used up.
    always_comb begin
        d = DIR_PE;
        if (pkt[HX_MSB:HX_LSB] != 8'd0) begin
            d = pkt[DIRX] ? DIR_W : DIR_E;
        end else if (pkt[HY_MSB:HY_LSB] != 8'd0) begin
            d = pkt[DIRY] ? DIR_S : DIR_N;
        end
        route = dir_onehot(d);
        dir   = d;
    end

    // The routed field is nonzero by construction, so the decrement cannot wrap.
    always_comb begin
        held_dec = held;
        if (held_route[DIR_E] | held_route[DIR_W]) begin
            held_dec[HX_MSB:HX_LSB] = held[HX_MSB:HX_LSB] - 8'd1;
        end else if (held_route[DIR_N] | held_route[DIR_S]) begin
            held_dec[HY_MSB:HY_LSB] = held[HY_MSB:HY_LSB] - 8'd1;
        end
    end

endmodule

// File: rtl/inbuf_route.sv
// inbuf_route: single-entry input buffer with XY route computation for one
// router input port.
//
// Upstream handshake: the upstream side may present a packet on di with si
// high during phase_external. The transfer completes at the clock edge where
// phase_external & si & ri all hold. ri is ~full and is combinational, so the
// upstream side may use it in the same cycle. If si is raised while the
// buffer is full, the packet is dropped and the sticky ovf flag is set.
// Crossbar side: req names the output wanted while full. The packet leaves at
// the edge where phase_internal & gnt & full hold, and dout shows it in that
// cycle only.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   si, ri, di      upstream strobe, ready and data
//   phase_external  link phase (enables capture)
//   phase_internal  crossbar phase (enables dequeue)
//   req             one-hot output request {PE, W, E, S, N}, 0 when empty
//   gnt             crossbar grant
//   dout            outgoing packet with its hop updated, 0 when not dequeuing
//   full            buffer occupied (the whole state: EMPTY/FULL)
//   q               stored raw packet
//   pkt_cnt         packets accepted since reset, wraps
//   ovf, uturn      sticky error flags
module inbuf_route
    import cd_pkg::*;
#(
    parameter int IN_DIR = 0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             si,
    output logic             ri,
    input  logic [63:0]      di,
    input  logic             phase_external,
    input  logic             phase_internal,
    output logic [REQ_W-1:0] req,
    input  logic             gnt,
    output logic [63:0]      dout,
    output logic             full,
    output logic [63:0]      q,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic             ovf,
    output logic             uturn
);

    localparam logic [2:0] IN_CODE  = IN_DIR[2:0];
    // A port facing the PE cannot U-turn.
    localparam logic       UTURN_EN = (IN_DIR != int'(DIR_PE));

    logic [REQ_W-1:0] route_r;
    logic [REQ_W-1:0] new_route;
    logic [2:0]       new_dir;
    logic [63:0]      q_dec;
    logic             capture;
    logic             deq;
    logic             drop;

    // Capture needs ~full and dequeue needs full, so they never coincide.
    assign capture = phase_external & si & ~full;
    assign drop    = phase_external & si & full;
    assign deq     = phase_internal & gnt & full;

    route_xy u_route (
        .pkt        (di),
        .route      (new_route),
        .dir        (new_dir),
        .held       (q),
        .held_route (route_r),
        .held_dec   (q_dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            full    <= 1'b0;
            q       <= '0;
            route_r <= '0;
            pkt_cnt <= '0;
            ovf     <= 1'b0;
            uturn   <= 1'b0;
        end else begin
            if (capture) begin
                full    <= 1'b1;
                q       <= di;
                route_r <= new_route;
                pkt_cnt <= pkt_cnt + CNT_W'(1);
                if (UTURN_EN && new_dir == IN_CODE) begin
                    uturn <= 1'b1;
                end
            end else if (deq) begin
                full <= 1'b0;
            end
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    assign ri   = ~full;
    assign req  = full ? route_r : '0;
    assign dout = deq ? q_dec : 64'd0;

endmodule

// File: tb/tb_inbuf_route.sv
// tb_inbuf_route: randomized and directed checks of inbuf_route against a
// transaction-level reference model, with an expected-output queue.
module tb_inbuf_route;

    localparam int CNT_W  = 4;
    localparam int IN_DIR = 2;  // faces east

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             si = 1'b0;
    logic             ri;
    logic [63:0]      di = '0;
    logic             phase_external = 1'b0;
    logic             phase_internal = 1'b0;
    logic [4:0]       req;
    logic             gnt = 1'b0;
    logic [63:0]      dout;
    logic             full;
    logic [63:0]      q;
    logic [CNT_W-1:0] pkt_cnt;
    logic             ovf;
    logic             uturn;

    inbuf_route #(.IN_DIR(IN_DIR), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .si             (si),
        .ri             (ri),
        .di             (di),
        .phase_external (phase_external),
        .phase_internal (phase_internal),
        .req            (req),
        .gnt            (gnt),
        .dout           (dout),
        .full           (full),
        .q              (q),
        .pkt_cnt        (pkt_cnt),
        .ovf            (ovf),
        .uturn          (uturn)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- counters and scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    bit mon_on = 1'b0;

    // Reference model: buffer contents as a transaction-level picture.
    bit               m_full  = 1'b0;
    logic [63:0]      m_q     = '0;
    logic [CNT_W-1:0] m_cnt   = '0;
    bit               m_ovf   = 1'b0;
    bit               m_uturn = 1'b0;

    // Direction code from the routing rule: X first, then Y, else PE.
    function automatic int route_of(input logic [63:0] p);
        if (p[55:48] != 8'd0) return p[62] ? 3 : 2;
        if (p[47:40] != 8'd0) return p[61] ? 1 : 0;
        return 4;
    endfunction

    // Packet as it should leave: one hop consumed in the routed dimension.
    function automatic logic [63:0] hop_dec(input logic [63:0] p);
        int r;
        r = route_of(p);
        if (r == 2 || r == 3) return p - (64'd1 << 48);
        if (r == 0 || r == 1) return p - (64'd1 << 40);
        return p;
    endfunction

    function automatic logic [63:0] make_pkt(input int hx, input int hy);
        logic [63:0] p;
        p = {$urandom, $urandom};
        p[55:48] = hx[7:0];
        p[47:40] = hy[7:0];
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Drives one cycle of inputs, then advances the model across the edge.
    task automatic step(input bit rst, input bit pe, input bit pi, input bit s,
                        input bit g, input logic [63:0] d);
        bit cap;
        bit dq;
        @(negedge clk);
        reset          = rst;
        phase_external = pe;
        phase_internal = pi;
        si             = s;
        gnt            = g;
        di             = d;
        @(posedge clk);
        if (rst) begin
            m_full  = 1'b0;
            m_q     = '0;
            m_cnt   = '0;
            m_ovf   = 1'b0;
            m_uturn = 1'b0;
            exp_q.delete();
        end else begin
            cap = pe && s && !m_full;
            dq  = pi && g && m_full;
            if (pe && s && m_full) m_ovf = 1'b1;
            if (dq) m_full = 1'b0;
            if (cap) begin
                m_full = 1'b1;
                m_q    = d;
                m_cnt  = m_cnt + 1'b1;
                if (route_of(d) == IN_DIR && IN_DIR != 4) m_uturn = 1'b1;
                exp_q.push_back(hop_dec(d));
            end
        end
    endtask

    task automatic send(input logic [63:0] p);
        step(0, 1, 0, 1, 0, p);
    endtask

    task automatic drain();
        step(0, 0, 1, 0, 1, 64'd0);
    endtask

    // ---------------- monitor ----------------
    // Checks state and combinational outputs mid-cycle, once inputs settle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_on) begin
                check("full", {63'd0, full}, {63'd0, m_full});
                check("ri", {63'd0, ri}, {63'd0, !m_full});
                check("q", q, m_q);
                check("req", {59'd0, req}, m_full ? (64'd1 << route_of(m_q)) : 64'd0);
                check("pkt_cnt", {60'd0, pkt_cnt}, {60'd0, m_cnt});
                check("ovf", {63'd0, ovf}, {63'd0, m_ovf});
                check("uturn", {63'd0, uturn}, {63'd0, m_uturn});
                if (phase_internal && gnt && full) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL dout_unexpected: got %h expected no packet", dout);
                    end else begin
                        check("dout", dout, exp_q.pop_front());
                    end
                end else begin
                    check("dout_idle", dout, 64'd0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] p;
        int hx;
        int hy;

        step(1, 0, 0, 0, 0, 64'd0);
        step(1, 0, 0, 0, 0, 64'd0);
        mon_on = 1'b1;
        step(0, 0, 0, 0, 0, 64'd0);
        step(0, 0, 1, 0, 1, 64'd0);  // grant while empty

        // East route, hopX=3; this port faces east so uturn sets.
        p = make_pkt(3, 0);
        p[62] = 1'b0;
        send(p);
        drain();
        // South route, hopY=2.
        p = make_pkt(0, 2);
        p[61] = 1'b1;
        send(p);
        drain();
        // PE route leaves the packet untouched.
        send(make_pkt(0, 0));
        drain();

        // Overflow: second send while held, grant outside internal phase.
        p = make_pkt(1, 1);
        p[62] = 1'b1;
        send(p);
        send(make_pkt(4, 4));
        step(0, 1, 0, 0, 1, 64'd0);
        drain();

        // Reset while full discards the packet and the flags.
        send(make_pkt(2, 0));
        step(1, 0, 0, 0, 0, 64'd0);
        step(0, 0, 0, 0, 0, 64'd0);

        // Both phases high: only one of capture/dequeue can qualify.
        step(0, 1, 1, 1, 1, make_pkt(0, 5));
        step(0, 1, 1, 1, 1, make_pkt(6, 0));
        step(0, 1, 1, 1, 1, make_pkt(6, 0));

        // Counter wrap: 2^CNT_W + 1 packets after reset.
        step(1, 0, 0, 0, 0, 64'd0);
        for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
            send(make_pkt($urandom_range(0, 3), $urandom_range(0, 3)));
            drain();
        end
        @(negedge clk);
        #3;
        check("cnt_wrap", {60'd0, pkt_cnt}, 64'd1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            hx = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 255);
            hy = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 255);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, make_pkt(hx, hy));
        end

        // Anything still held must come out on the next grant.
        drain();
        step(0, 0, 0, 0, 0, 64'd0);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
